// File: rtl/ohm_div_arbiter.sv
// ohm_div_arbiter: round-robin front end that shares one non-pipelined ohm_div
// resistance divider between NCH igniter channels. One conversion is in flight
// at a time: accept -> launch -> wait DIV_LAT cycles -> return tagged result.
// Optional build macro OHM_ARB_CH0_PRIO_EN gives channel 0 fixed top priority
// (rr_ptr is left untouched when channel 0 is served).
module ohm_div_arbiter #(
    parameter int NCH     = 4,
    parameter int DIV_LAT = 17,
    parameter int CHW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*12-1:0] req_v,
    input  logic [NCH*12-1:0] req_i,
    output logic [NCH-1:0]    req_ready,
    output logic              div_valid,
    output logic [11:0]       div_v,
    output logic [11:0]       div_i,
    input  logic              div_valid_out,
    input  logic [11:0]       div_r_out,
    output logic              rsp_valid,
    output logic [CHW-1:0]    rsp_ch,
    output logic [11:0]       rsp_r,
    output logic              rsp_lowi,
    output logic              busy,
    output logic              proto_err
);

    localparam int CNTW = $clog2(DIV_LAT + 1);
    localparam logic [CNTW-1:0] LAT_C = CNTW'(DIV_LAT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CHW-1:0]   rr_q, rr_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  ign_q, ign_d;
    logic [11:0]      v_q, v_d;
    logic [11:0]      i_q, i_d;
    logic [11:0]      rsp_r_q, rsp_r_d;
    logic             rsp_lowi_q, rsp_lowi_d;
    logic [CHW-1:0]   rsp_ch_q, rsp_ch_d;
    logic             proto_err_q, proto_err_d;

    logic             found;
    logic [CHW-1:0]   sel;
    logic [11:0]      sel_v, sel_i;
    logic             sample;

    // Pick the winning channel: first pending at or above rr_ptr, else lowest pending (wrap).
    always_comb begin
        found = 1'b0;
        sel   = '0;
`ifdef OHM_ARB_CH0_PRIO_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 0; k < NCH; k++) begin
            if (!found && req_valid[k] && (CHW'(k) >= rr_q)) begin
                found = 1'b1;
                sel   = CHW'(k);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (!found && req_valid[k]) begin
                found = 1'b1;
                sel   = CHW'(k);
            end
        end
    end

    // Route the winner's sample pair and drive the one-hot accept while idle.
    always_comb begin
        sel_v     = '0;
        sel_i     = '0;
        req_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            if (CHW'(k) == sel) begin
                sel_v = req_v[k*12 +: 12];
                sel_i = req_i[k*12 +: 12];
                req_ready[k] = (state_q == S_IDLE) && found;
            end
        end
    end

    // Conversion sequencer, result capture and protocol monitor.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        v_d         = v_q;
        i_d         = i_q;
        rsp_r_d     = rsp_r_q;
        rsp_lowi_d  = rsp_lowi_q;
        rsp_ch_d    = rsp_ch_q;
        sample      = (state_q == S_WAIT) && (cnt_q == LAT_C);
        // A strobe from a conversion aborted by reset may still arrive shortly after it.
        ign_d       = (ign_q != '0) ? ign_q - CNTW'(1) : ign_q;
        proto_err_d = proto_err_q | (div_valid_out && !sample && (ign_q == '0));

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ch_d    = sel;
                    v_d     = sel_v;
                    i_d     = sel_i;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = CNTW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sample) begin
                    rsp_r_d    = div_valid_out ? div_r_out : 12'h7FF;
                    rsp_lowi_d = !div_valid_out;
                    rsp_ch_d   = ch_q;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DONE: begin
`ifdef OHM_ARB_CH0_PRIO_EN
                if (ch_q != '0) begin
                    rr_d = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
                end
`else
                rr_d = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            ign_q       <= LAT_C;
            v_q         <= '0;
            i_q         <= '0;
            rsp_r_q     <= '0;
            rsp_lowi_q  <= 1'b0;
            rsp_ch_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            ign_q       <= ign_d;
            v_q         <= v_d;
            i_q         <= i_d;
            rsp_r_q     <= rsp_r_d;
            rsp_lowi_q  <= rsp_lowi_d;
            rsp_ch_q    <= rsp_ch_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign div_valid = (state_q == S_LAUNCH);
    assign div_v     = v_q;
    assign div_i     = i_q;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_ch    = rsp_ch_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_lowi  = rsp_lowi_q;
    assign busy      = (state_q != S_IDLE);
    assign proto_err = proto_err_q;

endmodule
